// File: rtl/sid_filter_seq.sv
// sid_filter_seq: sequences the time-multiplexed SID filter, muxing per-chip registers,
// computing the cutoff word F0 and capturing each chip's filtered audio.
module sid_filter_seq #(
  parameter bit         DUAL      = 1'b1,
  parameter logic [2:0] CAP_STATE = 3'd6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick,
  input  logic        mode0,
  input  logic        mode1,
  input  logic [10:0] fc0,
  input  logic [10:0] fc1,
  input  logic [7:0]  res_filt0,
  input  logic [7:0]  res_filt1,
  input  logic [7:0]  mode_vol0,
  input  logic [7:0]  mode_vol1,
  input  logic [17:0] audio_in,
  output logic [2:0]  state,
  output logic        chip,
  output logic        mode,
  output logic [15:0] F0,
  output logic [7:0]  res_filt,
  output logic [7:0]  mode_vol,
  output logic [17:0] audio0,
  output logic [17:0] audio1,
  output logic        valid,
  output logic        overrun
);
  typedef enum logic [2:0] {IDLE, P1, P2, P3, P4, P5, P6, P7} state_t;
  localparam logic [15:0] BASE  [8] = '{16'd220, 16'd260, 16'd340, 16'd500, 16'd900, 16'd1700, 16'd3300, 16'd6500};
  localparam logic [15:0] SLOPE [8] = '{16'd40, 16'd80, 16'd160, 16'd400, 16'd800, 16'd1600, 16'd3200, 16'd3000};
  state_t      cur, nxt;
  logic        chip_n, load;
  logic [10:0] fc_q;
  logic [10:0] mul_a;
  logic [15:0] mul_b, f0_calc;
  logic [26:0] prod;
  always_comb begin
    nxt    = cur;
    chip_n = chip;
    load   = 1'b0;
    if (cur == IDLE) begin
      if (tick) begin
        nxt    = P1;
        chip_n = 1'b0;
        load   = 1'b1;
      end
    end else if (cur == P7) begin
      load   = DUAL && !chip;
      nxt    = load ? P1 : IDLE;
      chip_n = load;
    end else begin
      nxt = state_t'(cur + 3'd1);
    end
  end
  // One shared multiplier: fc*19 for the 8580, slope*f for the 6581 segment curve
  assign mul_a   = mode ? fc_q : {3'b000, fc_q[7:0]};
  assign mul_b   = mode ? 16'd19 : SLOPE[fc_q[10:8]];
  assign prod    = 27'(mul_a) * 27'(mul_b);
  assign f0_calc = mode ? prod[17:2] : BASE[fc_q[10:8]] + prod[23:8];
  assign state   = cur;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur      <= IDLE;
      chip     <= 1'b0;
      mode     <= 1'b0;
      fc_q     <= '0;
      F0       <= '0;
      res_filt <= '0;
      mode_vol <= '0;
      audio0   <= '0;
      audio1   <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      cur  <= nxt;
      chip <= chip_n;
      if (load) begin
        mode     <= chip_n ? mode1 : mode0;
        fc_q     <= chip_n ? fc1 : fc0;
        res_filt <= chip_n ? res_filt1 : res_filt0;
        mode_vol <= chip_n ? mode_vol1 : mode_vol0;
      end
      if (cur == P1) F0 <= f0_calc;
      if (cur == CAP_STATE && !chip) audio0 <= audio_in;
      if (cur == CAP_STATE && chip) audio1 <= audio_in;
      valid <= (cur == CAP_STATE) && (!DUAL || chip);
      if (tick && cur != IDLE) overrun <= 1'b1;
    end
  end
endmodule
